mem_cell_server: RTL and testbench



---
 rtl/mem_cell_server_pkg.sv | 45 ++++
 rtl/mem_cell_server_cell_ram.sv | 27 ++
 rtl/mem_cell_server.sv | 161 ++++++++++++++++
 tb/tb_mem_cell_server.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_cell_server_pkg.sv
// rtl/mem_cell_server_pkg.sv - shared memory-unit protocol constants, cell field layout and FSM state type
package mem_cell_server_pkg;

    localparam int CELL_ADDR_WIDTH = 10;
    localparam int CELL_DATA_WIDTH = 64;
    localparam logic [CELL_ADDR_WIDTH-1:0] NIL_CELL = '1;

    localparam logic [1:0] FUNC_IDLE    = 2'b00;
    localparam logic [1:0] GET_CONTENTS = 2'b01;
    localparam logic [1:0] SET_CONTENTS = 2'b10;
    localparam logic [1:0] FUNC_BAD     = 2'b11;

    localparam int TAG_MSB = 63;
    localparam int TAG_LSB = 56;
    localparam int HED_MSB = 55;
    localparam int HED_LSB = 28;
    localparam int TEL_MSB = 27;
    localparam int TEL_LSB = 0;

    localparam int ERR_OVERFLOW = 0;
    localparam int ERR_NIL      = 1;
    localparam int ERR_FULL     = 2;
    localparam int ERR_FUNC     = 3;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    function automatic logic [CELL_DATA_WIDTH-1:0] make_cell(
        input logic [7:0]  tag,
        input logic [27:0] hed,
        input logic [27:0] tel
    );
        logic [CELL_DATA_WIDTH-1:0] c;
        c = '0;
        c[TAG_MSB:TAG_LSB] = tag;
        c[HED_MSB:HED_LSB] = hed;
        c[TEL_MSB:TEL_LSB] = tel;
        return c;
    endfunction

endpackage

// File: rtl/mem_cell_server_cell_ram.sv
// rtl/mem_cell_server_cell_ram.sv - single-port synchronous write-first cell RAM, one-cycle read latency
module cell_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                q         <= wdata;
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_cell_server.sv
// rtl/mem_cell_server.sv - memory-unit responder: heap clear, GET/SET service, one-deep pending slot, bump allocator
module mem_cell_server
    import mem_cell_server_pkg::*;
#(
    parameter int ADDR_WIDTH = CELL_ADDR_WIDTH,
    parameter int DATA_WIDTH = CELL_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_execute,
    input  logic [1:0]            mem_func,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic [ADDR_WIDTH-1:0] free_addr,
    output logic                  init_done,
    output logic [7:0]            error
);

    localparam logic [ADDR_WIDTH-1:0] NIL_ADDR  = '1;
    localparam logic [ADDR_WIDTH-1:0] LAST_FREE = NIL_ADDR - ADDR_WIDTH'(1);

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [1:0]            req_func, pend_func;
    logic [ADDR_WIDTH-1:0] req_addr, pend_addr;
    logic [DATA_WIDTH-1:0] req_data, pend_data;
    logic                  pend_valid;

    logic                  ram_en, ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_q;

    logic strobe, req_nil, req_get, req_set;
    logic take_pend, take_in, push_pend, drop;

    // func 00 strobes are ignored entirely, so they never occupy the pending slot
    assign strobe  = mem_execute && (mem_func != FUNC_IDLE);
    assign req_nil = (req_addr == NIL_ADDR);
    assign req_get = (req_func == GET_CONTENTS);
    assign req_set = (req_func == SET_CONTENTS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_CLEAR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = req_addr;
        ram_wdata  = req_data;
        take_pend  = 1'b0;
        take_in    = 1'b0;
        push_pend  = 1'b0;
        drop       = 1'b0;
        case (state)
            ST_CLEAR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_addr;
                ram_wdata = '0;
                if (clr_addr == NIL_ADDR) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (pend_valid) begin
                    take_pend  = 1'b1;
                    push_pend  = strobe;
                    state_next = ST_ACCESS;
                end else if (strobe) begin
                    take_in    = 1'b1;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ram_en     = (req_get || req_set) && !req_nil;
                ram_we     = req_set && !req_nil;
                state_next = ST_RESP;
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_CLEAR;
        endcase
        if (state != ST_IDLE && strobe) begin
            if (pend_valid) drop = 1'b1;
            else            push_pend = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr   <= '0;
            init_done  <= 1'b0;
            req_func   <= FUNC_IDLE;
            req_addr   <= '0;
            req_data   <= '0;
            pend_valid <= 1'b0;
            pend_func  <= FUNC_IDLE;
            pend_addr  <= '0;
            pend_data  <= '0;
            mem_ready  <= 1'b0;
            read_data  <= '0;
            free_addr  <= '0;
            error      <= '0;
        end else begin
            mem_ready <= (state == ST_RESP);

            if (state == ST_CLEAR) begin
                clr_addr <= clr_addr + ADDR_WIDTH'(1);
                if (clr_addr == NIL_ADDR) init_done <= 1'b1;
            end

            if (take_pend) begin
                req_func <= pend_func;
                req_addr <= pend_addr;
                req_data <= pend_data;
            end else if (take_in) begin
                req_func <= mem_func;
                req_addr <= address;
                req_data <= write_data;
            end

            if (push_pend) begin
                pend_valid <= 1'b1;
                pend_func  <= mem_func;
                pend_addr  <= address;
                pend_data  <= write_data;
            end else if (take_pend) begin
                pend_valid <= 1'b0;
            end

            if (drop) error[ERR_OVERFLOW] <= 1'b1;

            if (state == ST_RESP) begin
                if (req_get) read_data <= req_nil ? '0 : ram_q;
                if ((req_get || req_set) && req_nil) error[ERR_NIL] <= 1'b1;
                if (req_func == FUNC_BAD) error[ERR_FUNC] <= 1'b1;
                // a non-NIL address equal to free_addr implies free_addr is below NIL
                if (req_set && !req_nil && req_addr == free_addr) begin
                    free_addr <= free_addr + ADDR_WIDTH'(1);
                    if (free_addr == LAST_FREE) error[ERR_FULL] <= 1'b1;
                end
            end
        end
    end

    cell_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cell_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

endmodule

// File: tb/tb_mem_cell_server.sv
// tb/tb_mem_cell_server.sv - scoreboard bench for mem_cell_server
module tb_mem_cell_server;
    import mem_cell_server_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_execute = 1'b0;
    logic [1:0]  mem_func = 2'b00;
    logic [9:0]  address = '0;
    logic [63:0] write_data = '0;
    logic        mem_ready;
    logic [63:0] read_data;
    logic [9:0]  free_addr;
    logic        init_done;
    logic [7:0]  error;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct packed {
        logic        is_get;
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    logic [63:0] model [1024];

    mem_cell_server dut (
        .clk         (clk),
        .rst         (rst),
        .mem_execute (mem_execute),
        .mem_func    (mem_func),
        .address     (address),
        .write_data  (write_data),
        .mem_ready   (mem_ready),
        .read_data   (read_data),
        .free_addr   (free_addr),
        .init_done   (init_done),
        .error       (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (mem_ready === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ready cyc=%0d got=1 want=0", cyc);
                end else begin
                    e = sb.pop_front();
                    if (cyc != e.due) begin
                        bad++;
                        $display("FAIL ready_cycle got=%0d want=%0d", cyc, e.due);
                    end
                    if (e.is_get) begin
                        total++;
                        if (read_data !== e.data) begin
                            bad++;
                            $display("FAIL read_data got=%h want=%h", read_data, e.data);
                        end
                    end
                end
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL missing_ready cyc=%0d got=0 want=1 due=%0d", cyc, e.due);
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 1024; i++) model[i] = '0;
    endtask

    // Called just after an edge; the strobe is sampled on the next edge (k).
    task automatic strobe(input logic [1:0] func, input logic [9:0] addr,
                          input logic [63:0] data, input int lat, input bit resp);
        exp_t e;
        mem_execute = 1'b1;
        mem_func    = func;
        address     = addr;
        write_data  = data;
        if (resp) begin
            e.is_get = (func == GET_CONTENTS);
            e.data   = (addr == NIL_CELL) ? 64'h0 : model[addr];
            e.due    = cyc + 1 + lat;
            sb.push_back(e);
            if (func == SET_CONTENTS && addr != NIL_CELL) model[addr] = data;
        end
        @(posedge clk); #1;
        mem_execute = 1'b0;
        mem_func    = 2'b00;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending=%0d want=0", sb.size());
            sb.delete();
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 1100) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n != 1024) begin
            bad++;
            $display("FAIL %s_init_cycles got=%0d want=1024", tag, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_model();
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if ({mem_ready, read_data, free_addr, init_done, error} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%h/%h/%b/%h want=0",
                     mem_ready, read_data, free_addr, init_done, error);
        end
        rst = 1'b0;
        wait_init("reset");
        strobe(GET_CONTENTS, 10'd5, 64'h0, 2, 1'b1);
        wait_drain();
    endtask

    task automatic test_set_get();
        total++;
        if (free_addr !== 10'd0) begin
            bad++;
            $display("FAIL free_before_set got=%0d want=0", free_addr);
        end
        strobe(SET_CONTENTS, 10'd0, make_cell(8'h83, 28'h1, 28'h2), 2, 1'b1);
        wait_drain();
        total++;
        if (free_addr !== 10'd1) begin
            bad++;
            $display("FAIL free_after_set got=%0d want=1", free_addr);
        end
        strobe(GET_CONTENTS, 10'd0, 64'h0, 2, 1'b1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        strobe(SET_CONTENTS, 10'd1, 64'h1111_2222_3333_4444, 2, 1'b1);
        wait_drain();
        strobe(SET_CONTENTS, 10'd2, 64'hDEAD_BEEF_0BAD_F00D, 2, 1'b1);
        wait_drain();
        total++;
        if (free_addr !== 10'd3) begin
            bad++;
            $display("FAIL free_after_two got=%0d want=3", free_addr);
        end
        strobe(GET_CONTENTS, 10'd1, 64'h0, 2, 1'b1);
        strobe(GET_CONTENTS, 10'd2, 64'h0, 4, 1'b1);
        wait_drain();
        total++;
        if (error !== 8'h00) begin
            bad++;
            $display("FAIL b2b_error got=%h want=00", error);
        end
    endtask

    task automatic test_overflow();
        strobe(GET_CONTENTS, 10'd2, 64'h0, 2, 1'b1);
        strobe(GET_CONTENTS, 10'd1, 64'h0, 4, 1'b1);
        strobe(GET_CONTENTS, 10'd0, 64'h0, 0, 1'b0);
        wait_drain();
        total++;
        if (error !== 8'h01) begin
            bad++;
            $display("FAIL overflow_flag got=%h want=01", error);
        end
        strobe(GET_CONTENTS, 10'd0, 64'h0, 2, 1'b1);
        wait_drain();
        total++;
        if (error !== 8'h01) begin
            bad++;
            $display("FAIL overflow_sticky got=%h want=01", error);
        end
    endtask

    task automatic test_nil_func();
        strobe(GET_CONTENTS, NIL_CELL, 64'h0, 2, 1'b1);
        wait_drain();
        total++;
        if (error !== 8'h03) begin
            bad++;
            $display("FAIL nil_flag got=%h want=03", error);
        end
        strobe(FUNC_BAD, 10'd3, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b1);
        wait_drain();
        total++;
        if (error !== 8'h0B) begin
            bad++;
            $display("FAIL func_flag got=%h want=0b", error);
        end
        strobe(GET_CONTENTS, 10'd3, 64'h0, 2, 1'b1);
        wait_drain();
        strobe(2'b00, 10'd3, 64'h0, 0, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset_mid();
        bit saw_ready;
        saw_ready = 1'b0;
        strobe(SET_CONTENTS, 10'd7, 64'h7777_7777_7777_7777, 0, 1'b0);
        rst = 1'b1;
        clear_model();
        repeat (3) begin
            @(posedge clk); #1;
            if (mem_ready === 1'b1) saw_ready = 1'b1;
        end
        total++;
        if (saw_ready || init_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got=ready%0d/init%b want=ready0/init0", saw_ready, init_done);
        end
        rst = 1'b0;
        wait_init("remid");
        total++;
        if (free_addr !== 10'd0 || error !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_state got=free%0d/err%h want=free0/err00", free_addr, error);
        end
        strobe(GET_CONTENTS, 10'd7, 64'h0, 2, 1'b1);
        wait_drain();
    endtask

    task automatic test_heap_full();
        for (int i = 0; i < 1023; i++) begin
            strobe(SET_CONTENTS, 10'(i), {32'hA5A5_0000, i[31:0]}, 2, 1'b1);
            wait_drain();
            if (i == 1021) begin
                total++;
                if (error !== 8'h00) begin
                    bad++;
                    $display("FAIL full_early got=%h want=00", error);
                end
            end
        end
        total++;
        if (free_addr !== NIL_CELL || error !== 8'h04) begin
            bad++;
            $display("FAIL heap_full got=free%0d/err%h want=free1023/err04", free_addr, error);
        end
        strobe(SET_CONTENTS, 10'd1022, 64'h0123_4567_89AB_CDEF, 2, 1'b1);
        wait_drain();
        strobe(GET_CONTENTS, 10'd1022, 64'h0, 2, 1'b1);
        wait_drain();
        total++;
        if (free_addr !== NIL_CELL) begin
            bad++;
            $display("FAIL free_stuck got=%0d want=1023", free_addr);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_set_get();
        test_back_to_back();
        test_overflow();
        test_nil_func();
        test_reset_mid();
        test_heap_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
